// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX stage bundle: ID-side instruction fields and pipeline controls in, EX-side
// registered fields and event counters out.
interface id_ex_pipe_reg_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned WB_W   = 2,
    parameter int unsigned M_W    = 2,
    parameter int unsigned EX_W   = 4,
    parameter int unsigned CNT_W  = 16
);
    localparam int unsigned CTRL_W = WB_W + M_W + EX_W;

    logic              stall_i;
    logic              flush_i;
    logic              cnt_clr_i;
    logic              valid_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic [XLEN-1:0]   pc_i;
    logic [XLEN-1:0]   rs_data_i;
    logic [XLEN-1:0]   rt_data_i;
    logic [XLEN-1:0]   imm_i;
    logic [REG_AW-1:0] rs_i;
    logic [REG_AW-1:0] rt_i;
    logic [REG_AW-1:0] rd_i;

    logic              valid_o;
    logic [WB_W-1:0]   wb_o;
    logic [M_W-1:0]    mem_o;
    logic [EX_W-1:0]   ex_o;
    logic [XLEN-1:0]   pc_o;
    logic [XLEN-1:0]   rs_data_o;
    logic [XLEN-1:0]   rt_data_o;
    logic [XLEN-1:0]   imm_o;
    logic [REG_AW-1:0] rs_o;
    logic [REG_AW-1:0] rt_o;
    logic [REG_AW-1:0] rd_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  bubble_cnt_o;

    modport master (
        output stall_i, flush_i, cnt_clr_i, valid_i, ctrl_i, pc_i,
               rs_data_i, rt_data_i, imm_i, rs_i, rt_i, rd_i,
        input  valid_o, wb_o, mem_o, ex_o, pc_o, rs_data_o, rt_data_o,
               imm_o, rs_o, rt_o, rd_o, stall_cnt_o, bubble_cnt_o
    );

    modport slave (
        input  stall_i, flush_i, cnt_clr_i, valid_i, ctrl_i, pc_i,
               rs_data_i, rt_data_i, imm_i, rs_i, rt_i, rd_i,
        output valid_o, wb_o, mem_o, ex_o, pc_o, rs_data_o, rt_data_o,
               imm_o, rs_o, rt_o, rd_o, stall_cnt_o, bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid bit, stall/flush, and saturating stall and
// bubble event counters; a slot with valid_o=0 always carries all-zero control.
module id_ex_pipe_reg #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned WB_W   = 2,
    parameter int unsigned M_W    = 2,
    parameter int unsigned EX_W   = 4,
    parameter int unsigned CNT_W  = 16
) (
    input logic              clk,
    input logic              rst_i,
    id_ex_pipe_reg_if.slave  pipe
);
    localparam int unsigned CTRL_W = WB_W + M_W + EX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              valid_q,   valid_d;
    logic [WB_W-1:0]   wb_q,      wb_d;
    logic [M_W-1:0]    mem_q,     mem_d;
    logic [EX_W-1:0]   ex_q,      ex_d;
    logic [XLEN-1:0]   pc_q,      pc_d;
    logic [XLEN-1:0]   rs_data_q, rs_data_d;
    logic [XLEN-1:0]   rt_data_q, rt_data_d;
    logic [XLEN-1:0]   imm_q,     imm_d;
    logic [REG_AW-1:0] rs_q,      rs_d;
    logic [REG_AW-1:0] rt_q,      rt_d;
    logic [REG_AW-1:0] rd_q,      rd_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic              stall_ev;
    logic              bubble_ev;
    logic [CTRL_W-1:0] ctrl_gated;

    always_comb begin
        stall_ev   = pipe.stall_i & ~pipe.flush_i;
        bubble_ev  = pipe.flush_i | (~pipe.stall_i & ~pipe.valid_i);
        ctrl_gated = pipe.valid_i ? pipe.ctrl_i : '0;

        valid_d   = valid_q;
        wb_d      = wb_q;
        mem_d     = mem_q;
        ex_d      = ex_q;
        pc_d      = pc_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;

        if (pipe.flush_i) begin
            valid_d   = 1'b0;
            wb_d      = '0;
            mem_d     = '0;
            ex_d      = '0;
            pc_d      = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            rs_d      = '0;
            rt_d      = '0;
            rd_d      = '0;
        end else if (!pipe.stall_i) begin
            valid_d   = pipe.valid_i;
            wb_d      = ctrl_gated[WB_W-1:0];
            mem_d     = ctrl_gated[WB_W +: M_W];
            ex_d      = ctrl_gated[WB_W+M_W +: EX_W];
            pc_d      = pipe.pc_i;
            rs_data_d = pipe.rs_data_i;
            rt_data_d = pipe.rt_data_i;
            imm_d     = pipe.imm_i;
            rs_d      = pipe.rs_i;
            rt_d      = pipe.rt_i;
            rd_d      = pipe.rd_i;
        end

        // Clear overrides any increment; counters stop at all-ones instead of wrapping.
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (pipe.cnt_clr_i) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (stall_ev && stall_cnt_q != CNT_MAX)
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            if (bubble_ev && bubble_cnt_q != CNT_MAX)
                bubble_cnt_d = bubble_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            valid_q      <= 1'b0;
            wb_q         <= '0;
            mem_q        <= '0;
            ex_q         <= '0;
            pc_q         <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            wb_q         <= wb_d;
            mem_q        <= mem_d;
            ex_q         <= ex_d;
            pc_q         <= pc_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign pipe.valid_o      = valid_q;
    assign pipe.wb_o         = wb_q;
    assign pipe.mem_o        = mem_q;
    assign pipe.ex_o         = ex_q;
    assign pipe.pc_o         = pc_q;
    assign pipe.rs_data_o    = rs_data_q;
    assign pipe.rt_data_o    = rt_data_q;
    assign pipe.imm_o        = imm_q;
    assign pipe.rs_o         = rs_q;
    assign pipe.rt_o         = rt_q;
    assign pipe.rd_o         = rd_q;
    assign pipe.stall_cnt_o  = stall_cnt_q;
    assign pipe.bubble_cnt_o = bubble_cnt_q;
endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Parametrised ID/EX pipeline register for the five-stage core. Captures decoded control, operands, immediate and register specifiers from ID and presents them to EX one cycle later. Adds capabilities the fixed-width stage lacks: a valid bit, stall (hold), flush (bubble injection), synchronous reset, and saturating stall/bubble event counters for performance debug. Sits between the hazard/forwarding logic in ID and the ALU, forwarding unit and register-destination mux in EX.

## Interface
- XLEN, 32, width of PC, operand and immediate datapaths
- REG_AW, 5, register specifier width
- WB_W, 2, write-back control field width
- M_W, 2, memory control field width
- EX_W, 4, execute control field width (ALUSrc, ALUOp[1:0], RegDst at default)
- CNT_W, 16, event counter width
- Derived (not overridable): CTRL_W = WB_W+M_W+EX_W

- clk  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous active-high reset
- stall_i  in  1  hold current contents
- flush_i  in  1  load a bubble
- cnt_clr_i  in  1  clear both event counters
- valid_i  in  1  ID slot holds a real instruction
- ctrl_i  in  CTRL_W  packed control: [WB_W-1:0]=WB, next M_W bits=M, top EX_W bits=EX
- pc_i  in  XLEN  PC+4 of instruction
- rs_data_i, rt_data_i  in  XLEN each  register file read data
- imm_i  in  XLEN  sign-extended immediate
- rs_i, rt_i, rd_i  in  REG_AW each  register specifiers
- valid_o  out  1  EX slot valid
- wb_o  out  WB_W;  mem_o  out  M_W;  ex_o  out  EX_W  unpacked control fields
- pc_o, rs_data_o, rt_data_o, imm_o  out  XLEN each
- rs_o, rt_o, rd_o  out  REG_AW each
- stall_cnt_o, bubble_cnt_o  out  CNT_W each

## Operation
- Per-edge action, priority order: rst_i > flush_i > stall_i > load.
- Reset: every output, including counters, becomes 0.
- Flush: valid_o=0; wb_o, mem_o, ex_o, all data and specifier outputs = 0.
- Stall (no flush): all outputs except counters hold previous values.
- Load: all registers capture their inputs; valid_o=valid_i.
- Bubble from ID (load with valid_i=0): control outputs forced to 0 regardless of ctrl_i; data/specifier fields captured as presented.
- Control of a valid_o=0 slot is always zero, so downstream never writes registers or memory for a bubble.
- stall_cnt_o: +1 each edge where stall_i=1, flush_i=0, rst_i=0.
- bubble_cnt_o: +1 each edge where flush_i=1, or a load occurs with valid_i=0.
- Both counters saturate at 2^CNT_W-1 (no wrap).
- cnt_clr_i=1: both counters become 0 that edge, overriding any increment; does not affect pipeline contents.
- Reset also clears counters; cnt_clr_i has no effect during reset.

## Timing
- Latency: exactly one clock from inputs to outputs on a load.
- No combinational path input-to-output; all outputs are flop outputs.
- Stall held N cycles: outputs unchanged for N edges; first edge with stall_i=0 loads then-current inputs.
- stall_i and flush_i together: flush wins, bubble counted, stall not counted.
- Reset mid-stall or mid-flush: reset wins that edge; next edge behaves normally.
- Counter at max plus increment event: stays at max.

## Test plan
- Reset: drive rst_i=1 one edge with nonzero inputs -> all outputs 0, counters 0.
- Load: valid_i=1, ctrl_i=8'hA5, pc_i=32'h0000_0040, rs_data_i=32'h1234_5678, rd_i=5'd9 -> next edge valid_o=1, wb_o=2'b01, mem_o=2'b01, ex_o=4'hA, pc_o=32'h40, rd_o=9.
- Stall: load as above, then stall_i=1 for 3 cycles with pc_i=32'h44 -> outputs keep pc_o=32'h40, stall_cnt_o=3; release -> pc_o=32'h44.
- Flush priority: stall_i=1 and flush_i=1 together -> valid_o=0, all control/data 0, bubble_cnt_o +1, stall_cnt_o unchanged.
- Bubble from ID: valid_i=0, ctrl_i=8'hFF -> valid_o=0, wb_o=mem_o=ex_o=0, bubble_cnt_o +1.
- Saturation/clear (CNT_W=4): 20 stall cycles -> stall_cnt_o=15; cnt_clr_i=1 with stall_i=1 -> stall_cnt_o=0.
